// File: rtl/timing_pkg.sv
// rtl/timing_pkg.sv - shared types and constants for the LVDA master timing generator
package timing_pkg;

  typedef enum logic [2:0] {
    TG_IDLE = 3'd0,
    TG_W    = 3'd1,
    TG_X    = 3'd2,
    TG_Y    = 3'd3,
    TG_Z    = 3'd4
`ifdef TIMING_DEADBAND_EN
    ,
    TG_GAP  = 3'd5
`endif
  } tg_state_t;

  localparam logic [1:0] SLOT_W = 2'd0;
  localparam logic [1:0] SLOT_X = 2'd1;
  localparam logic [1:0] SLOT_Y = 2'd2;
  localparam logic [1:0] SLOT_Z = 2'd3;

  localparam int PHASE_COUNT = 4;

  function automatic logic is_slot(tg_state_t s);
    return (s == TG_W) || (s == TG_X) || (s == TG_Y) || (s == TG_Z);
  endfunction

  function automatic logic [1:0] slot_of(tg_state_t s);
    case (s)
      TG_X:    return SLOT_X;
      TG_Y:    return SLOT_Y;
      TG_Z:    return SLOT_Z;
      default: return SLOT_W;
    endcase
  endfunction

  function automatic tg_state_t slot_state(logic [1:0] idx);
    case (idx)
      SLOT_X:  return TG_X;
      SLOT_Y:  return TG_Y;
      SLOT_Z:  return TG_Z;
      default: return TG_W;
    endcase
  endfunction

endpackage

// File: rtl/timing_bt_counter.sv
// rtl/timing_bt_counter.sv - bit-time / phase-time counter pair with wrap
module timing_bt_counter
  import timing_pkg::*;
#(
  parameter int BITS_PER_PHASE = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [3:0] bt,
  output logic [1:0] ph,
  output logic       wrap
);

  // Last bit time of the phase: the next advance rolls into a new phase.
  always_comb begin
    wrap = (bt == 4'(BITS_PER_PHASE - 1));
  end

  // Step one bit time per advance; phase wraps 3 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bt <= 4'd0;
      ph <= 2'd0;
    end else if (advance) begin
      if (wrap) begin
        bt <= 4'd0;
        ph <= (ph == 2'(PHASE_COUNT - 1)) ? 2'd0 : ph + 2'd1;
      end else begin
        bt <= bt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/timing_gen.sv
// rtl/timing_gen.sv - W/X/Y/Z drive sequencer with run/stop/step control; optional TIMING_DEADBAND_EN
module timing_gen
  import timing_pkg::*;
#(
  parameter int SLOT_CYCLES    = 4,
  parameter int BITS_PER_PHASE = 14
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic       RUN,
  input  logic       STEP,
  output logic       WDA,
  output logic       XDA,
  output logic       YDA,
  output logic       ZDA,
  output logic [3:0] BT,
  output logic [1:0] PH,
  output logic       BT_START,
  output logic       PH_START,
  output logic       HALTED
);

  tg_state_t  state;
  tg_state_t  next_state;
  logic [7:0] sc;
  logic       slot_last;
  logic       advance;
  logic       wrap;

  logic [3:0] drive_d;
  logic       bt_start_d;
  logic       ph_start_d;
  logic       halted_d;

`ifdef TIMING_DEADBAND_EN
  logic [1:0] last_slot;
`endif

  timing_bt_counter #(
    .BITS_PER_PHASE(BITS_PER_PHASE)
  ) u_bt_counter (
    .clk    (SIM_CLK),
    .rst    (SIM_RST),
    .advance(advance),
    .bt     (BT),
    .ph     (PH),
    .wrap   (wrap)
  );

  always_comb begin
    slot_last = (sc == 8'(SLOT_CYCLES - 1));
  end

  // State register plus the in-slot cycle counter (cleared on every state change).
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state <= TG_IDLE;
      sc    <= 8'd0;
    end else begin
      state <= next_state;
      if (next_state != state || !is_slot(state)) begin
        sc <= 8'd0;
      end else begin
        sc <= sc + 8'd1;
      end
    end
  end

`ifdef TIMING_DEADBAND_EN
  // Remember which slot a GAP follows so the GAP knows where to go next.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      last_slot <= SLOT_W;
    end else if (is_slot(state)) begin
      last_slot <= slot_of(state);
    end
  end
`endif

  // Next-state logic; the bit time ends (and run control is sampled) after the Z slot.
  always_comb begin
    next_state = state;
    advance    = 1'b0;
    case (state)
      TG_IDLE: begin
        if (RUN || STEP) next_state = TG_W;
      end
      TG_W, TG_X, TG_Y: begin
        if (slot_last) begin
`ifdef TIMING_DEADBAND_EN
          next_state = TG_GAP;
`else
          next_state = slot_state(slot_of(state) + 2'd1);
`endif
        end
      end
      TG_Z: begin
        if (slot_last) begin
`ifdef TIMING_DEADBAND_EN
          next_state = TG_GAP;
`else
          advance    = 1'b1;
          next_state = RUN ? TG_W : TG_IDLE;
`endif
        end
      end
`ifdef TIMING_DEADBAND_EN
      TG_GAP: begin
        if (last_slot == SLOT_Z) begin
          advance    = 1'b1;
          next_state = RUN ? TG_W : TG_IDLE;
        end else begin
          next_state = slot_state(last_slot + 2'd1);
        end
      end
`endif
      default: next_state = TG_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output can be registered.
  always_comb begin
    drive_d = 4'b0000;
    if (is_slot(next_state)) begin
      drive_d[slot_of(next_state)] = 1'b1;
    end
    bt_start_d = (next_state == TG_W) && (state != TG_W);
    // A new bit time starting at BT=0 is either a wrap advance or a resume/start at 0.
    ph_start_d = bt_start_d && (advance ? wrap : (BT == 4'd0));
    halted_d   = (next_state == TG_IDLE);
  end

  // Registered outputs; reset drops any active drive on the next edge.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      WDA      <= 1'b0;
      XDA      <= 1'b0;
      YDA      <= 1'b0;
      ZDA      <= 1'b0;
      BT_START <= 1'b0;
      PH_START <= 1'b0;
      HALTED   <= 1'b1;
    end else begin
      WDA      <= drive_d[SLOT_W];
      XDA      <= drive_d[SLOT_X];
      YDA      <= drive_d[SLOT_Y];
      ZDA      <= drive_d[SLOT_Z];
      BT_START <= bt_start_d;
      PH_START <= ph_start_d;
      HALTED   <= halted_d;
    end
  end

endmodule

// File: tb/tb_timing_gen.sv
// tb/tb_timing_gen.sv - directed self-checking bench for timing_gen
module tb_timing_gen;

`ifdef TIMING_DEADBAND_EN
  localparam int SC  = 2;
  localparam int PER = SC + 1;
`else
  localparam int SC  = 4;
  localparam int PER = SC;
`endif
  localparam int BPP = 14;
  localparam int BL  = 4 * PER;

  logic       SIM_CLK;
  logic       SIM_RST;
  logic       RUN;
  logic       STEP;
  logic       WDA, XDA, YDA, ZDA;
  logic [3:0] BT;
  logic [1:0] PH;
  logic       BT_START;
  logic       PH_START;
  logic       HALTED;

  int total = 0;
  int bad   = 0;
  int m_bt  = 0;
  int m_ph  = 0;

  timing_gen #(
    .SLOT_CYCLES   (SC),
    .BITS_PER_PHASE(BPP)
  ) dut (
    .SIM_CLK (SIM_CLK),
    .SIM_RST (SIM_RST),
    .RUN     (RUN),
    .STEP    (STEP),
    .WDA     (WDA),
    .XDA     (XDA),
    .YDA     (YDA),
    .ZDA     (ZDA),
    .BT      (BT),
    .PH      (PH),
    .BT_START(BT_START),
    .PH_START(PH_START),
    .HALTED  (HALTED)
  );

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d bt=%0d ph=%0d", tag, got, exp, m_bt, m_ph);
    end
  endtask

  task automatic tick();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic adv_model();
    if (m_bt == BPP - 1) begin
      m_bt = 0;
      m_ph = (m_ph + 1) % 4;
    end else begin
      m_bt++;
    end
  endtask

  // off = cycle index within the current bit time, 0 = first W cycle
  task automatic check_cycle(input int off);
    int slot;
    int exp_dr;
    slot   = off / PER;
    exp_dr = ((off % PER) < SC) ? (8 >> slot) : 0;
    check_val("drives", int'({WDA, XDA, YDA, ZDA}), exp_dr);
    check_val("bt", int'(BT), m_bt);
    check_val("ph", int'(PH), m_ph);
    check_val("bt_start", int'(BT_START), (off == 0) ? 1 : 0);
    check_val("ph_start", int'(PH_START), (off == 0 && m_bt == 0) ? 1 : 0);
    check_val("halted_run", int'(HALTED), 0);
  endtask

  task automatic check_idle();
    check_val("idle_drives", int'({WDA, XDA, YDA, ZDA}), 0);
    check_val("idle_halted", int'(HALTED), 1);
    check_val("idle_bt", int'(BT), m_bt);
    check_val("idle_ph", int'(PH), m_ph);
    check_val("idle_bt_start", int'(BT_START), 0);
    check_val("idle_ph_start", int'(PH_START), 0);
  endtask

  task automatic run_bit();
    for (int off = 0; off < BL; off++) begin
      check_cycle(off);
      tick();
    end
    adv_model();
  endtask

  initial begin
    int guard;
    SIM_RST = 1'b1;
    RUN     = 1'b0;
    STEP    = 1'b0;
    tick();
    tick();
    SIM_RST = 1'b0;
    check_idle();
    tick();
    check_idle();

    // continuous run across four full phases and the 3 -> 0 wrap
    RUN = 1'b1;
    tick();
    repeat (61) run_bit();

    // drop RUN in the second X cycle of BT=5; Y and Z still complete
    check_val("drop_bt", int'(BT), 5);
    for (int off = 0; off < BL; off++) begin
      check_cycle(off);
      if (off == PER + 1) RUN = 1'b0;
      tick();
    end
    adv_model();
    check_idle();
    check_val("halt_bt", int'(BT), 6);
    repeat (3) begin
      tick();
      check_idle();
    end

    // single step from halt
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    run_bit();
    check_idle();
    check_val("step_bt", int'(BT), 7);
    tick();
    check_idle();

    // resume, with a STEP pulse while running that must be ignored
    RUN = 1'b1;
    tick();
    for (int off = 0; off < BL; off++) begin
      check_cycle(off);
      if (off == 3) STEP = 1'b1;
      if (off == 4) STEP = 1'b0;
      tick();
    end
    adv_model();

    guard = 0;
    while (!(m_bt == 9 && m_ph == 2) && guard < 100) begin
      run_bit();
      guard++;
    end
    check_val("reach_bt9_ph2", guard, 29);

    // reset asserted mid-Y
    for (int off = 0; off <= 2 * PER + 1; off++) begin
      check_cycle(off);
      if (off < 2 * PER + 1) tick();
    end
    SIM_RST = 1'b1;
    tick();
    m_bt = 0;
    m_ph = 0;
    check_idle();
    SIM_RST = 1'b0;
    RUN     = 1'b0;
    tick();
    check_idle();

    // restart after reset begins at BT=0 with a phase-start pulse
    RUN = 1'b1;
    tick();
    run_bit();
    RUN = 1'b0;
    run_bit();
    check_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
